mac_stream_array: RTL and testbench
===================================

# mac_stream_array

Parametrised ROW×COLUMN signed multiply-accumulate array with full stream handshake on input and output, shifted-in weight loading, and multi-beat accumulation from `first` to `last`. It sits between the convolution line-buffer/im2col stage (input vectors) and the requantisation stage (column results). It replaces the fixed 8-row, handshake-less MAC array in the CONV datapath.

## Interface
- DW, 8: input activation width, signed
- WW, 8: weight width, signed
- CW, 16: bias (`ci`) width per column, signed
- ROW, 8: rows; activation elements per beat; minimum 2
- COLUMN, 6: columns; results per packet
- AW, 32: internal accumulator width; must be ≥ DW+WW+$clog2(ROW)+4 and ≥ OW
- OW, 24: output width per column, signed
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- w_data  in  COLUMN*WW  one weight row; column c at [c*WW +: WW]
- w_valid  in  1  weight beat valid
- w_ready  out  1  weight beat accepted when w_valid && w_ready
- w_loaded  out  1  ROW weight beats accepted since reset
- mac_m_data  in  ROW*DW  activation vector; row r at [r*DW +: DW]
- ci  in  COLUMN*CW  per-column bias; sampled on the packet's first beat
- mac_m_first  in  1  first beat of packet
- mac_m_last  in  1  last beat of packet
- mac_m_valid  in  1  input beat valid
- mac_m_ready  out  1  input beat accepted when valid && ready
- mac_s_data  out  COLUMN*OW  per-column packet result
- mac_s_ovf  out  COLUMN  per-column overflow of result vs OW
- mac_s_valid  out  1  result valid
- mac_s_ready  in  1  result consumed when valid && ready
- err  out  1  sticky protocol error

## Operation
- Weight load: each accepted weight beat shifts rows: row r+1 ← row r, row 0 ← w_data. After ROW beats, the first beat sits in row ROW-1. A 0..ROW saturating counter drives w_loaded.
- w_ready = pipeline empty (no in-flight beat, no pending output) && !in_packet.
- mac_m_ready = ce && !(w_valid && w_ready); the weight beat wins when both are offered while idle.
- Datapath: per accepted beat, partial[c] = Σ_r x[r]·w[r][c], computed signed at full width and sign-extended to AW.
- Row r sees its activation through an r-cycle skew register; stage r adds row r's product.
- Accumulator FSM (in_packet bit):
  - A beat with first, or any beat while !in_packet: acc[c] = sext(ci[c]) + partial[c]; in_packet ← 1.
  - Any other beat: acc[c] += partial[c].
  - A beat with last: result registered to the output; in_packet ← 0.
  - first && last on the same beat gives a single-beat packet.
- A beat with first while in_packet discards the previous partial sum, restarts accumulation and sets err.
- Output: without saturation, mac_s_data[c] = acc[c][OW-1:0]. mac_s_ovf[c] = 1 when acc[c] lies outside the signed OW range.
- Accumulation wraps at AW bits; AW sizing prevents this for packets ≤ 16 beats.

## Timing
- Global clock enable ce = !mac_s_valid || mac_s_ready. When ce is low, the whole pipeline, skew registers and accumulator hold.
- Latency: a last beat accepted at edge k raises mac_s_valid after edge k+ROW+1, with no stalls in between.
- Throughput: one beat per cycle. A result is held stable, along with the input stall, until mac_s_ready.
- Reset values:
  - mac_s_valid=0, mac_s_data=0, mac_s_ovf=0, err=0, w_loaded=0, all weights=0, in_packet=0.
  - w_ready=1 and mac_m_ready=1 (absent w_valid) from the first edge after reset release.
- Reset mid-packet or mid-load drops all state immediately. There is no partial output.
- Weight beats are never accepted while a beat is in flight. Data already in the pipeline always uses the weights present at its acceptance.

## Configuration
- MAC_SATURATE_EN defined: mac_s_data[c] clamps to 2^(OW-1)-1 or -2^(OW-1) when mac_s_ovf[c] is set.
- MAC_SATURATE_EN undefined: mac_s_data[c] is truncated to the low OW bits (wrap).
- mac_s_ovf is generated in both builds.

## Structure
- Package mac_pkg: signed-extension/saturation function, shared width localparams (product width DW+WW, sum width), and a $clog2 helper.
- Sub-module mac_pe_row: one row. It holds COLUMN weight registers with shift-in, a skewed activation input, COLUMN multipliers, and COLUMN adders onto the incoming partial sums, all gated by ce. The top instantiates ROW copies via generate.

## Test plan
- Single-beat packet (ROW=8, COLUMN=6): load 8 weight beats of all 0x01; send x all 2, ci=0, first=last=1 -> each column 16, valid at k+9, ovf=0.
- Three-beat packet: weights 1, x all 1, ci=5 -> each column 5+24=29; only one output beat.
- Signed values: weights 3, x all 0xFF (-1), ci=-10, single beat -> each column -34 (0xFFFFDE at OW=24).
- Overflow (OW=16): weights 127, x all 127, 4-beat packet -> acc 516128; ovf=1.
  - With MAC_SATURATE_EN: data 0x7FFF.
  - Without MAC_SATURATE_EN: data 0xE020.
- Backpressure: hold mac_s_ready low 5 cycles with a result pending and valid input streaming -> mac_m_ready low, data stable, no beat lost or duplicated; results are correct after release.
- Protocol/reset:
  - first mid-packet -> err=1 sticky; result equals the restarted packet only.
  - rst_n low mid-packet -> all outputs return to reset values; w_loaded=0.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared helpers for the streaming MAC array: width derivation, a small
// clog2, and the signed overflow / saturation helpers used on the result path.
package mac_pkg;

    function automatic int mac_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int mac_prod_width(input int dw, input int ww);
        return dw + ww;
    endfunction

    function automatic int mac_sum_width(input int dw, input int ww, input int rows);
        return dw + ww + mac_clog2(rows);
    endfunction

    // Values are widened to 64 bits first, so any accumulator up to 64 bits fits.
    function automatic logic mac_ovf(input logic signed [63:0] v, input int ow);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (ow - 1));
        return (v > hi) || (v < lo);
    endfunction

    function automatic logic signed [63:0] mac_sat(input logic signed [63:0] v, input int ow);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (ow - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/mac_pe_row.sv
// One row of the MAC array: COLUMN shift-in weight registers, an SKEW-deep
// activation delay line, and COLUMN multiply-adds onto the incoming partial sums.
module mac_pe_row
    import mac_pkg::*;
#(
    parameter int DW     = 8,
    parameter int WW     = 8,
    parameter int COLUMN = 6,
    parameter int AW     = 32,
    parameter int SKEW   = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ce,
    input  logic                 w_shift,
    input  logic [COLUMN*WW-1:0] w_in,
    output logic [COLUMN*WW-1:0] w_out,
    input  logic [DW-1:0]        x_in,
    input  logic [COLUMN*AW-1:0] psum_in,
    output logic [COLUMN*AW-1:0] psum_out
);
    localparam int PW = mac_prod_width(DW, WW);

    logic [COLUMN*WW-1:0] w_q, w_d;
    logic [COLUMN*AW-1:0] psum_q, psum_d;
    logic [DW-1:0]        x_skewed;

    generate
        if (SKEW == 0) begin : g_noskew
            assign x_skewed = x_in;
        end else begin : g_skew
            logic [DW-1:0] skew_q [SKEW];
            logic [DW-1:0] skew_d [SKEW];

            always_comb begin
                skew_d = skew_q;
                if (ce) begin
                    skew_d[0] = x_in;
                    for (int i = 1; i < SKEW; i++) skew_d[i] = skew_q[i-1];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) skew_q <= '{default: '0};
                else        skew_q <= skew_d;
            end

            assign x_skewed = skew_q[SKEW-1];
        end
    endgenerate

    always_comb begin
        logic signed [PW-1:0] prod;
        prod   = '0;
        w_d    = w_q;
        psum_d = psum_q;
        if (w_shift) w_d = w_in;
        if (ce) begin
            for (int c = 0; c < COLUMN; c++) begin
                prod = $signed(x_skewed) * $signed(w_q[c*WW +: WW]);
                psum_d[c*AW +: AW] = psum_in[c*AW +: AW] + AW'(prod);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_q    <= '0;
            psum_q <= '0;
        end else begin
            w_q    <= w_d;
            psum_q <= psum_d;
        end
    end

    assign w_out    = w_q;
    assign psum_out = psum_q;

endmodule

// File: rtl/mac_stream_array.sv
// ROW x COLUMN signed streaming MAC array with first/last packet accumulation.
// Define MAC_SATURATE_EN to clamp overflowing results instead of wrapping them.
module mac_stream_array
    import mac_pkg::*;
#(
    parameter int DW     = 8,
    parameter int WW     = 8,
    parameter int CW     = 16,
    parameter int ROW    = 8,
    parameter int COLUMN = 6,
    parameter int AW     = 32,
    parameter int OW     = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [COLUMN*WW-1:0] w_data,
    input  logic                 w_valid,
    output logic                 w_ready,
    output logic                 w_loaded,
    input  logic [ROW*DW-1:0]    mac_m_data,
    input  logic [COLUMN*CW-1:0] ci,
    input  logic                 mac_m_first,
    input  logic                 mac_m_last,
    input  logic                 mac_m_valid,
    output logic                 mac_m_ready,
    output logic [COLUMN*OW-1:0] mac_s_data,
    output logic [COLUMN-1:0]    mac_s_ovf,
    output logic                 mac_s_valid,
    input  logic                 mac_s_ready,
    output logic                 err
);
    localparam int              CNTW   = mac_clog2(ROW + 1);
    localparam logic [CNTW-1:0] W_FULL = CNTW'(ROW);

    logic                 init_q, init_d;
    logic [CNTW-1:0]      w_cnt_q, w_cnt_d;
    logic [ROW-1:0]       vld_q, vld_d, first_q, first_d, last_q, last_d;
    logic [COLUMN*CW-1:0] ci_pipe_q [ROW];
    logic [COLUMN*CW-1:0] ci_pipe_d [ROW];
    logic signed [AW-1:0] acc_q [COLUMN];
    logic signed [AW-1:0] acc_d [COLUMN];
    logic                 in_packet_q, in_packet_d, acc_done_q, acc_done_d;
    logic                 err_q, err_d, out_valid_q, out_valid_d;
    logic [COLUMN*OW-1:0] out_data_q, out_data_d;
    logic [COLUMN-1:0]    out_ovf_q, out_ovf_d;
    logic                 ce, busy, w_accept, m_accept;
    logic [COLUMN*WW-1:0] w_chain [ROW+1];
    logic [COLUMN*AW-1:0] psum_chain [ROW+1];
    logic [COLUMN*WW-1:0] w_tail_unused;

    // Weights may only change when nothing is in flight, so every beat sees the weights of its acceptance.
    assign ce          = !out_valid_q || mac_s_ready;
    assign busy        = (|vld_q) || acc_done_q || out_valid_q || in_packet_q;
    assign w_ready     = init_q && !busy;
    assign w_accept    = w_valid && w_ready;
    assign mac_m_ready = init_q && ce && !w_accept;
    assign m_accept    = mac_m_valid && mac_m_ready;
    assign w_loaded    = (w_cnt_q == W_FULL);

    assign w_chain[0]    = w_data;
    assign psum_chain[0] = '0;
    assign w_tail_unused = w_chain[ROW];

    generate
        for (genvar r = 0; r < ROW; r++) begin : g_row
            mac_pe_row #(
                .DW(DW), .WW(WW), .COLUMN(COLUMN), .AW(AW), .SKEW(r)
            ) u_row (
                .clk      (clk),
                .rst_n    (rst_n),
                .ce       (ce),
                .w_shift  (w_accept),
                .w_in     (w_chain[r]),
                .w_out    (w_chain[r+1]),
                .x_in     (mac_m_data[r*DW +: DW]),
                .psum_in  (psum_chain[r]),
                .psum_out (psum_chain[r+1])
            );
        end
    endgenerate

    always_comb begin
        init_d    = 1'b1;
        w_cnt_d   = w_cnt_q;
        vld_d     = vld_q;
        first_d   = first_q;
        last_d    = last_q;
        ci_pipe_d = ci_pipe_q;
        if (w_accept && w_cnt_q != W_FULL) w_cnt_d = w_cnt_q + 1'b1;
        if (ce) begin
            vld_d        = {vld_q[ROW-2:0], m_accept};
            first_d      = {first_q[ROW-2:0], mac_m_first};
            last_d       = {last_q[ROW-2:0], mac_m_last};
            ci_pipe_d[0] = ci;
            for (int r = 1; r < ROW; r++) ci_pipe_d[r] = ci_pipe_q[r-1];
        end
    end

    // The accumulator sees a beat ROW cycles after acceptance; the output register adds one more.
    always_comb begin
        logic                 start;
        logic signed [AW-1:0] base;
        logic signed [63:0]   acc_wide;
`ifdef MAC_SATURATE_EN
        logic signed [63:0]   sat_v;
        sat_v = '0;
`endif
        start       = 1'b0;
        base        = '0;
        acc_wide    = '0;
        acc_d       = acc_q;
        in_packet_d = in_packet_q;
        acc_done_d  = acc_done_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        if (ce) begin
            acc_done_d = 1'b0;
            if (vld_q[ROW-1]) begin
                start = first_q[ROW-1] || !in_packet_q;
                if (first_q[ROW-1] && in_packet_q) err_d = 1'b1;
                for (int c = 0; c < COLUMN; c++) begin
                    base     = start ? AW'($signed(ci_pipe_q[ROW-1][c*CW +: CW])) : acc_q[c];
                    acc_d[c] = base + $signed(psum_chain[ROW][c*AW +: AW]);
                end
                in_packet_d = !last_q[ROW-1];
                acc_done_d  = last_q[ROW-1];
            end
            out_valid_d = acc_done_q;
            if (acc_done_q) begin
                for (int c = 0; c < COLUMN; c++) begin
                    acc_wide     = 64'(acc_q[c]);
                    out_ovf_d[c] = mac_ovf(acc_wide, OW);
`ifdef MAC_SATURATE_EN
                    sat_v = mac_sat(acc_wide, OW);
                    out_data_d[c*OW +: OW] = sat_v[OW-1:0];
`else
                    out_data_d[c*OW +: OW] = acc_q[c][OW-1:0];
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_q      <= 1'b0;
            w_cnt_q     <= '0;
            vld_q       <= '0;
            first_q     <= '0;
            last_q      <= '0;
            ci_pipe_q   <= '{default: '0};
            acc_q       <= '{default: '0};
            in_packet_q <= 1'b0;
            acc_done_q  <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= '0;
        end else begin
            init_q      <= init_d;
            w_cnt_q     <= w_cnt_d;
            vld_q       <= vld_d;
            first_q     <= first_d;
            last_q      <= last_d;
            ci_pipe_q   <= ci_pipe_d;
            acc_q       <= acc_d;
            in_packet_q <= in_packet_d;
            acc_done_q  <= acc_done_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign mac_s_valid = out_valid_q;
    assign mac_s_data  = out_data_q;
    assign mac_s_ovf   = out_ovf_q;
    assign err         = err_q;

endmodule

// File: tb/tb_mac_stream_array.sv
// Randomised self-checking bench for mac_stream_array against a packet-level
// reference model (weights kept as a history of loaded beats, sums in longint).
module tb_mac_stream_array;
    localparam int DW = 8, WW = 8, CW = 16, ROW = 8, COLUMN = 6, AW = 32, OW = 16;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [COLUMN*WW-1:0] w_data = '0;
    logic                 w_valid = 1'b0;
    logic                 w_ready, w_loaded;
    logic [ROW*DW-1:0]    mac_m_data = '0;
    logic [COLUMN*CW-1:0] ci = '0;
    logic                 mac_m_first = 1'b0, mac_m_last = 1'b0, mac_m_valid = 1'b0;
    logic                 mac_m_ready;
    logic [COLUMN*OW-1:0] mac_s_data;
    logic [COLUMN-1:0]    mac_s_ovf;
    logic                 mac_s_valid;
    logic                 mac_s_ready = 1'b1;
    logic                 err;

    always #5 clk = ~clk;

    mac_stream_array #(
        .DW(DW), .WW(WW), .CW(CW), .ROW(ROW), .COLUMN(COLUMN), .AW(AW), .OW(OW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready), .w_loaded(w_loaded),
        .mac_m_data(mac_m_data), .ci(ci), .mac_m_first(mac_m_first), .mac_m_last(mac_m_last),
        .mac_m_valid(mac_m_valid), .mac_m_ready(mac_m_ready),
        .mac_s_data(mac_s_data), .mac_s_ovf(mac_s_ovf), .mac_s_valid(mac_s_valid),
        .mac_s_ready(mac_s_ready), .err(err)
    );

    typedef struct {
        logic [COLUMN*OW-1:0] data;
        logic [COLUMN-1:0]    ovf;
    } result_t;

    int                   assertCount = 0;
    int                   failCount = 0;
    result_t              expQ[$];
    logic [COLUMN*WW-1:0] wHist[$];
    longint               accModel[COLUMN];
    bit                   inPktModel = 1'b0;
    bit                   errModel = 1'b0;
    bit                   randReady = 1'b0;
    result_t              monExp;
    logic [COLUMN*OW-1:0] heldData;
    bit                   heldValid = 1'b0;

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Row r holds the beat loaded r beats before the most recent one.
    function automatic longint weightAt(int r, int c);
        logic [COLUMN*WW-1:0] beat;
        if (r >= wHist.size()) return 0;
        beat = wHist[wHist.size()-1-r];
        return longint'($signed(beat[c*WW +: WW]));
    endfunction

    function automatic longint wrapAw(longint v);
        logic signed [AW-1:0] t;
        t = v[AW-1:0];
        return longint'(t);
    endfunction

    task automatic modelAccept(input logic [ROW*DW-1:0] x, input logic [COLUMN*CW-1:0] ciV,
                               input bit first, input bit last);
        bit      restart;
        longint  partial, v, maxV, minV;
        result_t res;
        maxV    = (longint'(1) << (OW-1)) - 1;
        minV    = -(longint'(1) << (OW-1));
        restart = first || !inPktModel;
        if (first && inPktModel) errModel = 1'b1;
        for (int c = 0; c < COLUMN; c++) begin
            partial = 0;
            for (int r = 0; r < ROW; r++)
                partial += longint'($signed(x[r*DW +: DW])) * weightAt(r, c);
            if (restart) accModel[c] = longint'($signed(ciV[c*CW +: CW])) + partial;
            else         accModel[c] = accModel[c] + partial;
            accModel[c] = wrapAw(accModel[c]);
            v = accModel[c];
            res.ovf[c] = (v > maxV) || (v < minV);
`ifdef MAC_SATURATE_EN
            if (v > maxV) v = maxV;
            if (v < minV) v = minV;
`endif
            res.data[c*OW +: OW] = v[OW-1:0];
        end
        inPktModel = !last;
        if (last) expQ.push_back(res);
    endtask

    task automatic applyStimulus(input logic [ROW*DW-1:0] x, input logic [COLUMN*CW-1:0] ciV,
                                 input bit first, input bit last);
        mac_m_data  = x;
        ci          = ciV;
        mac_m_first = first;
        mac_m_last  = last;
        mac_m_valid = 1'b1;
        for (int n = 0; n < 500; n++) begin
            #1;
            if (mac_m_ready) begin
                modelAccept(x, ciV, first, last);
                @(negedge clk);
                mac_m_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        checkOutput("m_ready_timeout", mac_m_ready, 1);
        mac_m_valid = 1'b0;
    endtask

    task automatic loadWeight(input logic [COLUMN*WW-1:0] w);
        w_data  = w;
        w_valid = 1'b1;
        for (int n = 0; n < 500; n++) begin
            #1;
            if (w_ready) begin
                wHist.push_back(w);
                @(negedge clk);
                w_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        checkOutput("w_ready_timeout", w_ready, 1);
        w_valid = 1'b0;
    endtask

    task automatic loadUniform(input logic [WW-1:0] w);
        for (int i = 0; i < ROW; i++) loadWeight({COLUMN{w}});
    endtask

    task automatic loadRandom();
        logic [COLUMN*WW-1:0] w;
        for (int i = 0; i < ROW; i++) begin
            for (int c = 0; c < COLUMN; c++) w[c*WW +: WW] = WW'($urandom);
            loadWeight(w);
        end
    endtask

    task automatic sendRandomPacket(input int len);
        logic [ROW*DW-1:0]    x;
        logic [COLUMN*CW-1:0] c16;
        for (int c = 0; c < COLUMN; c++) c16[c*CW +: CW] = CW'($urandom);
        for (int i = 0; i < len; i++) begin
            for (int r = 0; r < ROW; r++) x[r*DW +: DW] = DW'($urandom);
            applyStimulus(x, c16, i == 0, i == len - 1);
        end
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while ((expQ.size() != 0 || mac_s_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) checkOutput("drain_timeout", expQ.size(), 0);
    endtask

    always @(negedge clk) begin
        if (randReady) mac_s_ready = ($urandom_range(0, 3) != 0);
    end

    // Output monitor: result scoreboard plus stall behaviour while a result is held.
    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            if (mac_s_valid && !mac_s_ready) begin
                checkOutput("stall_m_ready", mac_m_ready, 0);
                if (heldValid) checkOutput("stall_data_stable", mac_s_data, heldData);
                heldData  = mac_s_data;
                heldValid = 1'b1;
            end else begin
                heldValid = 1'b0;
            end
            if (mac_s_valid && mac_s_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_result", mac_s_valid, 0);
                end else begin
                    monExp = expQ.pop_front();
                    checkOutput("result_data", mac_s_data, monExp.data);
                    checkOutput("result_ovf", mac_s_ovf, monExp.ovf);
                end
            end
        end else begin
            heldValid = 1'b0;
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int                   n;
        logic [DW-1:0]        xb;
        logic [CW-1:0]        cb;
        logic [ROW*DW-1:0]    x;

        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_s_valid", mac_s_valid, 0);
        checkOutput("rst_s_data", mac_s_data, 0);
        checkOutput("rst_s_ovf", mac_s_ovf, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_w_loaded", w_loaded, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("post_rst_w_ready", w_ready, 1);
        checkOutput("post_rst_m_ready", mac_m_ready, 1);
        @(negedge clk);

        $display("[TB] single-beat packet");
        for (int i = 0; i < ROW - 1; i++) loadWeight({COLUMN{8'h01}});
        checkOutput("w_loaded_partial", w_loaded, 0);
        loadWeight({COLUMN{8'h01}});
        checkOutput("w_loaded_full", w_loaded, 1);
        xb = 8'd2;
        applyStimulus({ROW{xb}}, '0, 1'b1, 1'b1);
        n = 0;
        while (n < 40) begin
            #2;
            if (mac_s_valid) break;
            @(negedge clk);
            n++;
        end
        checkOutput("latency", n, ROW + 1);
        @(negedge clk);
        waitDrain();

        $display("[TB] three-beat packet");
        xb = 8'd1;
        cb = 16'd5;
        applyStimulus({ROW{xb}}, {COLUMN{cb}}, 1'b1, 1'b0);
        applyStimulus({ROW{xb}}, {COLUMN{cb}}, 1'b0, 1'b0);
        applyStimulus({ROW{xb}}, {COLUMN{cb}}, 1'b0, 1'b1);
        waitDrain();

        $display("[TB] signed values");
        loadUniform(8'd3);
        xb = 8'hFF;
        cb = 16'hFFF6;
        applyStimulus({ROW{xb}}, {COLUMN{cb}}, 1'b1, 1'b1);
        waitDrain();

        $display("[TB] overflow");
        loadUniform(8'd127);
        xb = 8'd127;
        for (int i = 0; i < 4; i++) applyStimulus({ROW{xb}}, '0, i == 0, i == 3);
        waitDrain();

        $display("[TB] backpressure");
        loadRandom();
        mac_s_ready = 1'b0;
        fork
            begin
                for (int p = 0; p < 6; p++) sendRandomPacket($urandom_range(1, 2));
            end
            begin
                int k;
                k = 0;
                while (!mac_s_valid && k < 200) begin
                    @(negedge clk);
                    k++;
                end
                checkOutput("bp_valid_seen", mac_s_valid, 1);
                repeat (5) @(negedge clk);
                mac_s_ready = 1'b1;
            end
        join
        waitDrain();

        $display("[TB] random traffic");
        randReady = 1'b1;
        for (int it = 0; it < 12; it++) begin
            if ($urandom_range(0, 3) == 0) loadRandom();
            sendRandomPacket($urandom_range(1, 5));
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        randReady = 1'b0;
        @(negedge clk);
        mac_s_ready = 1'b1;
        waitDrain();
        checkOutput("err_clean", err, errModel);

        $display("[TB] first inside packet");
        loadRandom();
        for (int r = 0; r < ROW; r++) x[r*DW +: DW] = DW'($urandom);
        applyStimulus(x, {COLUMN{16'd100}}, 1'b1, 1'b0);
        applyStimulus(x, {COLUMN{16'd100}}, 1'b0, 1'b0);
        for (int r = 0; r < ROW; r++) x[r*DW +: DW] = DW'($urandom);
        applyStimulus(x, {COLUMN{16'd7}}, 1'b1, 1'b0);
        applyStimulus(x, {COLUMN{16'd7}}, 1'b0, 1'b1);
        waitDrain();
        checkOutput("err_set", err, errModel);
        sendRandomPacket(2);
        waitDrain();
        checkOutput("err_sticky", err, 1);

        $display("[TB] reset mid-packet");
        sendRandomPacket(1);
        for (int r = 0; r < ROW; r++) x[r*DW +: DW] = DW'($urandom);
        applyStimulus(x, '0, 1'b1, 1'b0);
        applyStimulus(x, '0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_s_valid", mac_s_valid, 0);
        checkOutput("midrst_s_data", mac_s_data, 0);
        checkOutput("midrst_s_ovf", mac_s_ovf, 0);
        checkOutput("midrst_err", err, 0);
        checkOutput("midrst_w_loaded", w_loaded, 0);
        expQ.delete();
        wHist.delete();
        inPktModel = 1'b0;
        errModel   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("midrst_w_ready", w_ready, 1);
        @(negedge clk);
        for (int r = 0; r < ROW; r++) x[r*DW +: DW] = DW'($urandom);
        applyStimulus(x, {COLUMN{16'd7}}, 1'b1, 1'b1);
        waitDrain();
        checkOutput("midrst_w_loaded_after", w_loaded, 0);
        checkOutput("queue_empty", expQ.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
